inst_fetch_loader: RTL and testbench
====================================

Name: inst_fetch_loader

Overview:
Parametrised successor to the single-byte-path fetch stage: instruction memory, program loader and fetch pipeline register in one block.
- Loader assembles an 8-bit byte stream into INST_WIDTH-bit words and writes them sequentially from address 0.
- Flushes any partial word on end, reports word count and overflow, and gates instruction fetch until the memory is coherent.
- Sits between the program loader (UART side) and the decode stage.

Parameters:
INST_MEM_WIDTH, 10, instruction address width; memory depth = 2**INST_MEM_WIDTH words
INST_WIDTH, 32, instruction width in bits; must be a multiple of 8 (BYTES = INST_WIDTH/8)
BIG_ENDIAN, 1, 1: first received byte lands in the MSBs; 0: first byte lands in the LSBs

Ports:
CLK  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
pc  input  INST_MEM_WIDTH  fetch address for this cycle
pc1  input  INST_MEM_WIDTH  companion pc (pc+1), pipelined alongside pc
input_data  input  8  loader byte
input_start  input  1  loader start pulse
input_end  input  1  loader end pulse
input_valid  input  1  input_data valid this cycle
inst  output  INST_WIDTH  instruction at pc, registered (1-cycle latency)
inst_enable  output  1  inst valid; decode may consume
pc_next  output  INST_MEM_WIDTH  pc delayed one cycle, aligned with inst
pc1_next  output  INST_MEM_WIDTH  pc1 delayed one cycle
loading  output  1  high in LOAD or DRAIN
load_count  output  INST_MEM_WIDTH+1  words written by the current/last load
load_overflow  output  1  sticky: bytes arrived after memory was full

Behaviour:
- Reset (reset=0, async):
  - State=RUN; inst=0, pc_next=0, pc1_next=0, inst_enable=0, loading=0, load_count=0, load_overflow=0.
  - Byte counter=0, assembly register=0.
  - Memory contents are not cleared.
  - First cycle after reset release: inst_enable=1 (one-cycle read latency).
- States:
  - RUN: the fetch reads mem[pc] each cycle. inst and pc_next/pc1_next update together on the next edge. inst_enable=1 except in the first RUN cycle after DRAIN or reset.
  - LOAD:
    - Entered on input_start from any state; start has priority over end in the same cycle.
    - Clears load_count, the byte counter, load_overflow and the assembly register.
    - inst_enable=0; pc_next/pc1_next keep tracking pc/pc1.
  - DRAIN:
    - Entered from LOAD on input_end.
    - If the byte counter is nonzero, writes the partial word to mem[load_count] with missing bytes zero, and increments load_count (if not full).
    - Always exactly one cycle, then RUN.
- LOAD byte handling (input_valid=1):
  - Byte is placed at byte slot k = byte counter.
    - BIG_ENDIAN=1: slot k occupies bits [INST_WIDTH-1-8k -: 8].
    - BIG_ENDIAN=0: slot k occupies bits [8k +: 8].
  - When k = BYTES-1, the completed word (including this byte) is written to mem[load_count] in the same edge; load_count increments and the counter wraps to 0.
  - A byte with input_valid in the same cycle as input_end is accepted before the drain.
- Full: when load_count = 2**INST_MEM_WIDTH:
  - Further valid bytes are dropped and load_overflow sets.
  - No writes occur; the address never wraps.
- Pulses outside their state are ignored: input_end in RUN; input_valid in RUN/DRAIN.
- Write and read in the same cycle cannot collide, since reads are only enabled in RUN.
- Reset asserted mid-load: immediate return to RUN; words already written are kept; the partial word is discarded.

Test Plan:
- Reset, then RUN with pc=5, pc1=6 after preloading mem[5]=0xDEADBEEF -> next cycle inst=0xDEADBEEF, pc_next=5, pc1_next=6, inst_enable=1.
- input_start; bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88; input_end (BIG_ENDIAN=1):
  - mem[0]=0x11223344, mem[1]=0x55667788, load_count=2.
  - inst_enable=0 throughout load and DRAIN, and 1 from the second RUN cycle.
- BIG_ENDIAN=0 load of 0xAA,0xBB,0xCC then input_end together with a valid byte 0xDD -> mem[0]=0xDDCCBBAA, load_count=1.
- Partial flush: bytes 0x01,0x02 then input_end -> mem[0]=0x01020000 (BIG_ENDIAN=1), load_count=1.
- INST_MEM_WIDTH=2: 20 bytes loaded -> mem[0..3] written, load_count=4, load_overflow=1, no address wrap; a new input_start clears load_overflow.
- Reset low after 6 bytes -> outputs at reset values immediately; mem[0] holds its written word, mem[1] unchanged; input_start and input_end asserted together -> LOAD entered.

Source files
------------

// File: rtl/inst_fetch_loader.sv
// Instruction memory with byte-stream program loader and registered fetch stage.
// Bytes are packed into INST_WIDTH-bit words and written from address 0 upward.
// Fetch is gated off while loading and for one cycle after the memory settles.
module inst_fetch_loader #(
    parameter int unsigned INST_MEM_WIDTH = 10,
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned BIG_ENDIAN     = 1
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [7:0]                input_data,
    input  logic                      input_start,
    input  logic                      input_end,
    input  logic                      input_valid,
    output logic [INST_WIDTH-1:0]     inst,
    output logic                      inst_enable,
    output logic [INST_MEM_WIDTH-1:0] pc_next,
    output logic [INST_MEM_WIDTH-1:0] pc1_next,
    output logic                      loading,
    output logic [INST_MEM_WIDTH:0]   load_count,
    output logic                      load_overflow
);

    localparam int unsigned BYTES = INST_WIDTH / 8;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned DEPTH = 2 ** INST_MEM_WIDTH;
    localparam int unsigned LCW   = INST_MEM_WIDTH + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    state;
    logic [CW-1:0]             byte_cnt;
    logic [INST_WIDTH-1:0]     asm_word;
    logic [INST_WIDTH-1:0]     mem [DEPTH];

    logic                      mem_full_c;
    logic                      last_byte_c;
    logic                      byte_ok_c;
    logic [INST_WIDTH-1:0]     byte_word_c;
    logic [INST_WIDTH-1:0]     merged_c;
    logic                      wr_en_c;
    logic [INST_MEM_WIDTH-1:0] wr_addr_c;
    logic [INST_WIDTH-1:0]     wr_data_c;

    // Place the incoming byte into its slot according to byte order
    always_comb begin
        byte_word_c = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (byte_cnt == CW'(i)) begin
                if (BIG_ENDIAN != 0)
                    byte_word_c[(INST_WIDTH - 8 - 8 * i) +: 8] = input_data;
                else
                    byte_word_c[(8 * i) +: 8] = input_data;
            end
        end
    end

    // Memory write decode: completed word in LOAD, or partial flush in DRAIN
    always_comb begin
        mem_full_c  = load_count[INST_MEM_WIDTH];
        last_byte_c = (byte_cnt == CW'(BYTES - 1));
        byte_ok_c   = (state == S_LOAD) && input_valid && !input_start && !mem_full_c;
        merged_c    = asm_word | byte_word_c;
        wr_en_c     = 1'b0;
        wr_addr_c   = load_count[INST_MEM_WIDTH-1:0];
        wr_data_c   = merged_c;
        if (byte_ok_c && last_byte_c) begin
            wr_en_c = 1'b1;
        end else if ((state == S_DRAIN) && !input_start && (byte_cnt != '0) && !mem_full_c) begin
            wr_en_c   = 1'b1;
            wr_data_c = asm_word;
        end
    end

    // Instruction storage; contents survive reset
    always_ff @(posedge CLK) begin
        if (wr_en_c)
            mem[wr_addr_c] <= wr_data_c;
    end

    // Control FSM, loader counters and registered fetch outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state         <= S_RUN;
            inst          <= '0;
            inst_enable   <= 1'b0;
            pc_next       <= '0;
            pc1_next      <= '0;
            loading       <= 1'b0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            byte_cnt      <= '0;
            asm_word      <= '0;
        end else begin
            pc_next  <= pc;
            pc1_next <= pc1;
            if (input_start) begin
                state         <= S_LOAD;
                loading       <= 1'b1;
                inst_enable   <= 1'b0;
                load_count    <= '0;
                load_overflow <= 1'b0;
                byte_cnt      <= '0;
                asm_word      <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        inst        <= mem[pc];
                        inst_enable <= 1'b1;
                    end
                    S_LOAD: begin
                        inst_enable <= 1'b0;
                        if (input_valid) begin
                            if (mem_full_c) begin
                                load_overflow <= 1'b1;
                            end else if (last_byte_c) begin
                                load_count <= load_count + LCW'(1);
                                byte_cnt   <= '0;
                                asm_word   <= '0;
                            end else begin
                                asm_word <= merged_c;
                                byte_cnt <= byte_cnt + CW'(1);
                            end
                        end
                        if (input_end)
                            state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        inst_enable <= 1'b0;
                        if ((byte_cnt != '0) && !mem_full_c)
                            load_count <= load_count + LCW'(1);
                        byte_cnt <= '0;
                        asm_word <= '0;
                        state    <= S_RUN;
                        loading  <= 1'b0;
                    end
                    default: begin
                        state       <= S_RUN;
                        loading     <= 1'b0;
                        inst_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_loader.sv
// Directed bench for inst_fetch_loader: big-endian, little-endian and small-memory
// instances share one stimulus stream; each is checked against hand-computed words.
module tb_inst_fetch_loader;

    logic        CLK;
    logic        reset;
    logic [9:0]  pc;
    logic [9:0]  pc1;
    logic [7:0]  input_data;
    logic        input_start;
    logic        input_end;
    logic        input_valid;

    logic [31:0] be_inst, le_inst, sm_inst;
    logic        be_en, le_en, sm_en;
    logic [9:0]  be_pcn, be_pc1n, le_pcn, le_pc1n;
    logic [1:0]  sm_pcn, sm_pc1n;
    logic        be_ld, le_ld, sm_ld;
    logic [10:0] be_lc, le_lc;
    logic [2:0]  sm_lc;
    logic        be_ovf, le_ovf, sm_ovf;

    int n_vec;
    int n_bad;

    inst_fetch_loader #(.INST_MEM_WIDTH(10), .INST_WIDTH(32), .BIG_ENDIAN(1)) dut_be (
        .CLK(CLK), .reset(reset), .pc(pc), .pc1(pc1),
        .input_data(input_data), .input_start(input_start), .input_end(input_end),
        .input_valid(input_valid), .inst(be_inst), .inst_enable(be_en),
        .pc_next(be_pcn), .pc1_next(be_pc1n), .loading(be_ld),
        .load_count(be_lc), .load_overflow(be_ovf)
    );

    inst_fetch_loader #(.INST_MEM_WIDTH(10), .INST_WIDTH(32), .BIG_ENDIAN(0)) dut_le (
        .CLK(CLK), .reset(reset), .pc(pc), .pc1(pc1),
        .input_data(input_data), .input_start(input_start), .input_end(input_end),
        .input_valid(input_valid), .inst(le_inst), .inst_enable(le_en),
        .pc_next(le_pcn), .pc1_next(le_pc1n), .loading(le_ld),
        .load_count(le_lc), .load_overflow(le_ovf)
    );

    inst_fetch_loader #(.INST_MEM_WIDTH(2), .INST_WIDTH(32), .BIG_ENDIAN(1)) dut_sm (
        .CLK(CLK), .reset(reset), .pc(pc[1:0]), .pc1(pc1[1:0]),
        .input_data(input_data), .input_start(input_start), .input_end(input_end),
        .input_valid(input_valid), .inst(sm_inst), .inst_enable(sm_en),
        .pc_next(sm_pcn), .pc1_next(sm_pc1n), .loading(sm_ld),
        .load_count(sm_lc), .load_overflow(sm_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        input_valid = 1'b1;
        input_data  = b;
        tick();
        input_valid = 1'b0;
    endtask

    task automatic send_word_be(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic start_load();
        input_start = 1'b1;
        tick();
        input_start = 1'b0;
    endtask

    // End pulse, then the DRAIN cycle; leaves all DUTs in their first RUN cycle
    task automatic end_load();
        input_end = 1'b1;
        tick();
        input_end = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [9:0] a);
        pc  = a;
        pc1 = a + 10'd1;
        tick();
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        pc          = '0;
        pc1         = '0;
        input_data  = '0;
        input_start = 1'b0;
        input_end   = 1'b0;
        input_valid = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_inst", 64'(be_inst), 64'h0);
        chk("rst_en", 64'(be_en), 64'h0);
        chk("rst_loading", 64'(be_ld), 64'h0);
        chk("rst_lc", 64'(be_lc), 64'h0);
        chk("rst_ovf", 64'(be_ovf), 64'h0);
        reset = 1'b1;
        tick();
        chk("post_rst_en", 64'(be_en), 64'h1);

        // Preload words 0..5 with word 5 = DEADBEEF, then fetch pc=5
        start_load();
        for (int i = 0; i < 5; i++) send_word_be(32'h1000_0000 + 32'(i));
        send_word_be(32'hDEADBEEF);
        end_load();
        fetch(10'd5);
        chk("pre_inst", 64'(be_inst), 64'hDEADBEEF);
        chk("pre_pcn", 64'(be_pcn), 64'd5);
        chk("pre_pc1n", 64'(be_pc1n), 64'd6);
        chk("pre_en", 64'(be_en), 64'h1);
        chk("pre_lc", 64'(be_lc), 64'd6);
        chk("pre_le_inst", 64'(le_inst), 64'hEFBEADDE);
        chk("pre_sm_lc", 64'(sm_lc), 64'd4);
        chk("pre_sm_ovf", 64'(sm_ovf), 64'h1);

        // Two-word big-endian load with enable gating
        start_load();
        chk("ld_loading", 64'(be_ld), 64'h1);
        chk("ld_en", 64'(be_en), 64'h0);
        send_word_be(32'h11223344);
        send_word_be(32'h55667788);
        chk("ld_en_mid", 64'(be_en), 64'h0);
        input_end = 1'b1;
        tick();
        input_end = 1'b0;
        chk("drain_loading", 64'(be_ld), 64'h1);
        chk("drain_en", 64'(be_en), 64'h0);
        tick();
        chk("run1_loading", 64'(be_ld), 64'h0);
        chk("run1_en", 64'(be_en), 64'h0);
        fetch(10'd0);
        chk("w0_inst", 64'(be_inst), 64'h11223344);
        chk("w0_en", 64'(be_en), 64'h1);
        chk("w0_le_inst", 64'(le_inst), 64'h44332211);
        fetch(10'd1);
        chk("w1_inst", 64'(be_inst), 64'h55667788);
        chk("w_lc", 64'(be_lc), 64'd2);

        // Three bytes then a fourth byte arriving with the end pulse
        start_load();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        input_valid = 1'b1;
        input_data  = 8'hDD;
        input_end   = 1'b1;
        tick();
        input_valid = 1'b0;
        input_end   = 1'b0;
        tick();
        fetch(10'd0);
        chk("endbyte_le", 64'(le_inst), 64'hDDCCBBAA);
        chk("endbyte_le_lc", 64'(le_lc), 64'd1);
        chk("endbyte_be", 64'(be_inst), 64'hAABBCCDD);

        // Partial word flush on end
        start_load();
        send_byte(8'h01);
        send_byte(8'h02);
        end_load();
        fetch(10'd0);
        chk("partial_be", 64'(be_inst), 64'h01020000);
        chk("partial_lc", 64'(be_lc), 64'd1);
        chk("partial_le", 64'(le_inst), 64'h00000201);

        // 20 bytes into the 4-word instance: fill, overflow, no wrap
        start_load();
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
        end_load();
        chk("ovf_sm_lc", 64'(sm_lc), 64'd4);
        chk("ovf_sm_flag", 64'(sm_ovf), 64'h1);
        chk("ovf_be_lc", 64'(be_lc), 64'd5);
        chk("ovf_be_flag", 64'(be_ovf), 64'h0);
        fetch(10'd0);
        chk("ovf_sm_w0", 64'(sm_inst), 64'h01020304);
        fetch(10'd3);
        chk("ovf_sm_w3", 64'(sm_inst), 64'h0D0E0F10);
        start_load();
        chk("ovf_clear", 64'(sm_ovf), 64'h0);
        chk("ovf_clear_lc", 64'(sm_lc), 64'd0);
        end_load();

        // Reset in the middle of a load
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'hA1 + 8'(i));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_loading", 64'(be_ld), 64'h0);
        chk("mid_rst_lc", 64'(be_lc), 64'h0);
        chk("mid_rst_en", 64'(be_en), 64'h0);
        chk("mid_rst_inst", 64'(be_inst), 64'h0);
        chk("mid_rst_pcn", 64'(be_pcn), 64'h0);
        reset = 1'b1;
        tick();
        chk("mid_rst_run_en", 64'(be_en), 64'h1);
        fetch(10'd0);
        chk("mid_rst_w0", 64'(be_inst), 64'hA1A2A3A4);
        fetch(10'd1);
        chk("mid_rst_w1", 64'(be_inst), 64'h05060708);
        input_start = 1'b1;
        input_end   = 1'b1;
        tick();
        input_start = 1'b0;
        chk("start_prio_loading", 64'(be_ld), 64'h1);
        chk("start_prio_en", 64'(be_en), 64'h0);
        tick();
        input_end = 1'b0;
        tick();
        chk("final_loading", 64'(be_ld), 64'h0);
        chk("final_lc", 64'(be_lc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
